// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the register bank write port.
// ALU (port 0) and load (port 1) requesters share the port through
// valid/ready handshakes with round-robin arbitration on conflicts. The
// winning write is registered onto W/C/Cdata one cycle after the handshake.
// Optional macro WB_BYPASS_EN adds a write-through read bypass
// (byp_addr/byp_rf_data/byp_data) covering the bank's post-edge write delay.
module regbank_wb_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned ZERO_REG   = 31,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic [31:0]       busy,
  output logic              W,
  output logic [ADDR_W-1:0] C,
  output logic [DATA_W-1:0] Cdata
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_rf_data,
  output logic [DATA_W-1:0] byp_data
`endif
);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_e;

  localparam logic [ADDR_W-1:0] ZR_ADDR = ADDR_W'(ZERO_REG);
  localparam prio_e RST_PTR = (RESET_PRIO != 0) ? PRIO_MEM : PRIO_ALU;

  prio_e             rr_ptr;
  prio_e             rr_ptr_nxt;
  logic              wr_take;
  logic              wr_any;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       busy_nxt;

  // Grant selection, pointer advance and winning write selection.
  always_comb begin
    alu_ready  = !RST && alu_valid && (!mem_valid || rr_ptr == PRIO_ALU);
    mem_ready  = !RST && mem_valid && (!alu_valid || rr_ptr == PRIO_MEM);
    rr_ptr_nxt = rr_ptr;
    if (alu_valid && mem_valid)
      rr_ptr_nxt = (rr_ptr == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;
    wr_addr = alu_ready ? alu_addr : mem_addr;
    wr_data = alu_ready ? alu_data : mem_data;
    wr_any  = alu_ready || mem_ready;
    wr_take = wr_any && (wr_addr != ZR_ADDR);
  end

  // Scoreboard next state: clear on the write edge, then set so a newer
  // producer issued on the same edge keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < 32; i++) begin
      if (W && C == ADDR_W'(i))
        busy_nxt[i] = 1'b0;
      if (sb_set && sb_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST)
      rr_ptr <= RST_PTR;
    else
      rr_ptr <= rr_ptr_nxt;
  end

  // Registered bank write port; XZR transfers handshake but never write,
  // and C/Cdata hold whenever no write is issued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      W     <= 1'b0;
      C     <= '0;
      Cdata <= '0;
    end else begin
      W <= wr_take;
      if (wr_take) begin
        C     <= wr_addr;
        Cdata <= wr_data;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge CLK) begin
    if (RST)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to readers of the same register.
  always_comb begin
    byp_data = byp_rf_data;
    if (W && C == byp_addr && byp_addr != ZR_ADDR)
      byp_data = Cdata;
  end
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench for regbank_wb_arbiter: a bench-side reference model
// predicts grants and pushes the expected write-port state for each edge
// into a queue; it is popped and compared one cycle later.
module tb_regbank_wb_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam logic [4:0]  XZR    = 5'd31;

  logic              CLK = 1'b0;
  logic              RST;
  logic              alu_valid, mem_valid, sb_set;
  logic [ADDR_W-1:0] alu_addr, mem_addr, sb_addr;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready;
  logic [31:0]       busy;
  logic              W;
  logic [ADDR_W-1:0] C;
  logic [DATA_W-1:0] Cdata;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr;
  logic [DATA_W-1:0] byp_rf_data;
  logic [DATA_W-1:0] byp_data;
`endif

  regbank_wb_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .ZERO_REG(31),
    .RESET_PRIO(0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .alu_valid(alu_valid),
    .alu_addr(alu_addr),
    .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .sb_set(sb_set),
    .sb_addr(sb_addr),
    .busy(busy),
    .W(W),
    .C(C),
    .Cdata(Cdata)
`ifdef WB_BYPASS_EN
    ,
    .byp_addr(byp_addr),
    .byp_rf_data(byp_rf_data),
    .byp_data(byp_data)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        w;
    logic        chk;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        m_rr;
  logic [31:0] m_busy;
  logic        m_w;
  logic [4:0]  m_c;
  logic        m_ar, m_mr;
  logic [63:0] mon_bank [32];

  function automatic exp_t mk(input logic w, input logic chk,
                              input logic [4:0] addr, input logic [63:0] data);
    exp_t e;
    e.w = w; e.chk = chk; e.addr = addr; e.data = data;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic step();
    exp_t        e;
    exp_t        n;
    logic [31:0] nb;
    @(negedge CLK);
    m_ar = !RST && alu_valid && (!mem_valid || m_rr == 1'b0);
    m_mr = !RST && mem_valid && (!alu_valid || m_rr == 1'b1);
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, m_ar});
    chk("mem_ready", {63'd0, mem_ready}, {63'd0, m_mr});
    chk("busy", {32'd0, busy}, {32'd0, m_busy});
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 64'd1, 64'd0);
      e = mk(1'b0, 1'b0, 5'd0, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("W", {63'd0, W}, {63'd0, e.w});
      if (e.chk) begin
        chk("C", {59'd0, C}, {59'd0, e.addr});
        chk("Cdata", Cdata, e.data);
      end
    end
    if (W === 1'b1) mon_bank[C] = Cdata;
`ifdef WB_BYPASS_EN
    chk("byp_data", byp_data,
        (e.w && e.addr == byp_addr && byp_addr != XZR) ? e.data : byp_rf_data);
`endif
    if (RST) begin
      n      = mk(1'b0, 1'b1, 5'd0, 64'd0);
      m_busy = '0;
      m_rr   = 1'b0;
      m_w    = 1'b0;
    end else begin
      nb = m_busy;
      if (m_w) nb[m_c] = 1'b0;
      if (sb_set && sb_addr != XZR) nb[sb_addr] = 1'b1;
      m_busy = nb;
      if (m_ar)
        n = mk(alu_addr != XZR, alu_addr != XZR, alu_addr, alu_data);
      else if (m_mr)
        n = mk(mem_addr != XZR, mem_addr != XZR, mem_addr, mem_data);
      else
        n = mk(1'b0, 1'b0, 5'd0, 64'd0);
      if (alu_valid && mem_valid) m_rr = !m_rr;
      m_w = n.w;
      if (n.w) m_c = n.addr;
    end
    exp_q.push_back(n);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    sb_set    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mon_bank[i] = '0;
    // Reset with both requesters valid and a scoreboard set pending.
    RST = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'h11;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 64'h22;
    sb_set = 1'b1; sb_addr = 5'd4;
`ifdef WB_BYPASS_EN
    byp_addr = 5'd0; byp_rf_data = 64'h0;
`endif
    m_rr = 1'b0; m_busy = '0; m_w = 1'b0; m_c = '0;
    @(posedge CLK); #1;
    exp_q.push_back(mk(1'b0, 1'b1, 5'd0, 64'd0));
    step(); step();

    // First conflict after reset goes to ALU, then MEM; reg3 ends with MEM data.
    RST = 1'b0; sb_set = 1'b0;
    step();
    alu_valid = 1'b0;
    step();
    idle(); step(); step();
    chk("bank_r3", mon_bank[3], 64'h22);

    // Single ALU write.
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'hDEAD_BEEF;
    step();
    idle(); step(); step();
    chk("bank_r5", mon_bank[5], 64'hDEAD_BEEF);

    // XZR: handshake completes, no write, no busy bit.
    mem_valid = 1'b1; mem_addr = XZR; mem_data = 64'h99;
    sb_set = 1'b1; sb_addr = XZR;
    step();
    idle(); step(); step();

    // Scoreboard set then cleared by the write.
    sb_set = 1'b1; sb_addr = 5'd7; step();
    idle(); step(); step();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'h77; step();
    idle(); step(); step();
    // Same again, but re-issue reg7 on the clearing edge.
    sb_set = 1'b1; sb_addr = 5'd7; step();
    idle(); step();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 64'h78; step();
    idle(); sb_set = 1'b1; sb_addr = 5'd7; step();
    idle(); step(); step();

    // Bypass hit and miss while W=1, C=9.
`ifdef WB_BYPASS_EN
    byp_addr = 5'd9; byp_rf_data = 64'h0;
`endif
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'h55; step();
    idle(); step();
`ifdef WB_BYPASS_EN
    byp_addr = 5'd10; byp_rf_data = 64'hAAAA;
`endif
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'h56; step();
    idle(); step();

    // Back-to-back MEM writes keep W high.
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(12 + i); mem_data = 64'(100 + i);
      step();
    end
    idle(); step();

    // Random traffic; a stalled requester holds its request stable.
    for (int i = 0; i < 300; i++) begin
      if (!alu_valid || m_ar) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = 5'($urandom_range(0, 31));
        alu_data  = {$urandom, $urandom};
      end
      if (!mem_valid || m_mr) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_addr  = 5'($urandom_range(0, 31));
        mem_data  = {$urandom, $urandom};
      end
      sb_set  = ($urandom_range(0, 1) != 0);
      sb_addr = 5'($urandom_range(0, 31));
      RST     = ($urandom_range(0, 49) == 0);
`ifdef WB_BYPASS_EN
      byp_addr    = 5'($urandom_range(0, 31));
      byp_rf_data = {$urandom, $urandom};
`endif
      step();
    end
    RST = 1'b0; idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32x64 register bank's single write port (C, Cdata, W).
- Shares that port between two requesters, ALU result (port 0) and memory load (port 1), using valid/ready handshakes and round-robin arbitration.
- Registers the winning write onto the bank's write port.
- Keeps a 32-bit busy scoreboard so decode can stall on pending destination registers.
- Sits between the execute/memory stages and the register bank.

Parameters:
DATA_W, 64, data width of the write port
ADDR_W, 5, register address width
ZERO_REG, 31, register index hardwired to zero (XZR); writes to it are dropped
RESET_PRIO, 0, requester that wins the first conflict after reset (0=ALU, 1=MEM)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
alu_valid  in  1  ALU write request valid
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU write data
alu_ready  out  1  ALU request accepted this cycle (combinational)
mem_valid  in  1  load write request valid
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load write data
mem_ready  out  1  load request accepted this cycle (combinational)
sb_set  in  1  decode issues an instruction with a destination
sb_addr  in  ADDR_W  destination register to mark busy
busy  out  32  scoreboard; bit r=1 means a write to r is pending
W  out  1  register bank write enable (registered)
C  out  ADDR_W  register bank write address (registered)
Cdata  out  DATA_W  register bank write data (registered)

Behaviour:
- Reset (RST=1 at a clock edge):
  - W=0, C=0, Cdata=0, busy=0.
  - rr_ptr=RESET_PRIO. rr_ptr names the requester preferred on the next conflict.
  - RST dominates any simultaneous request or sb_set.
  - A request present during reset is not accepted; ready=0 while RST=1.
- Arbitration (combinational; the write port never back-pressures):
  - Only one requester valid: its ready=1.
  - Both valid: the requester named by rr_ptr gets ready=1; the other gets ready=0 and must hold valid, addr and data stable until accepted.
  - Neither valid: both ready=0.
- rr_ptr update:
  - After any conflict cycle, rr_ptr flips to the loser.
  - Single-requester cycles leave rr_ptr unchanged.
- Transfer: valid && ready at a clock edge.
  - Next cycle: W=1, C=addr, Cdata=data. Latency is exactly 1 cycle; at most one write per cycle.
  - No transfer: W=0 next cycle; C and Cdata hold their previous values.
- XZR:
  - A transfer with addr==ZERO_REG completes the handshake, but W stays 0 next cycle.
  - sb_set with sb_addr==ZERO_REG is ignored; busy[ZERO_REG] is always 0.
- Scoreboard:
  - At each edge, busy[sb_addr] is set if sb_set.
  - At each edge, busy[C] is cleared if W=1, i.e. on the same edge the bank captures the write.
  - Same register set and cleared on the same edge: set wins (a newer producer was issued).
  - Set of an already-busy register: stays 1 (no counting; the pipeline guarantees one outstanding producer per register).
- Same destination from both requesters in one cycle: serialized by arbitration. The bank sees the winner first, then the loser; the final bank value is the loser's data.
- Back-to-back: a requester holding valid with no competition transfers every cycle, so W stays high continuously.

Optional Feature:
WB_BYPASS_EN:
- Defined: adds ports byp_addr (in, ADDR_W), byp_rf_data (in, DATA_W; bank read data for byp_addr) and byp_data (out, DATA_W).
  - byp_data=Cdata when W=1 and C==byp_addr and byp_addr!=ZERO_REG; otherwise byp_data=byp_rf_data (combinational).
  - This covers the bank's post-edge write delay.
- Undefined: these ports do not exist; the behaviour of all other ports is identical.

Test Plan:
- Reset: RST=1 for 2 cycles with both requests valid -> W=0, C=0, Cdata=0, busy=0, alu_ready=mem_ready=0; first conflict after release is granted to ALU (RESET_PRIO=0).
- Single ALU write: alu_valid=1, alu_addr=5, alu_data=0xDEAD_BEEF for one cycle -> alu_ready=1; next cycle W=1, C=5, Cdata=0xDEADBEEF; following cycle W=0.
- Conflict: both valid for 2 cycles, ALU addr=3 data=0x11, MEM addr=3 data=0x22 -> grants ALU then MEM; W=1 for 2 cycles with Cdata 0x11 then 0x22; bank reg3 reads 0x22.
- XZR: mem_valid=1, mem_addr=31; sb_set=1, sb_addr=31 -> mem_ready=1, W stays 0, busy[31]=0.
- Scoreboard: sb_set reg7; two cycles later ALU writes reg7 -> busy[7]=1 until the edge where W=1, C=7, then 0. Repeat with sb_set reg7 on that same edge -> busy[7] remains 1.
- Bypass (WB_BYPASS_EN defined): W=1, C=9, Cdata=0x55, byp_addr=9, byp_rf_data=0x0 -> byp_data=0x55; byp_addr=10 -> byp_data=byp_rf_data.
